// File: rtl/bcd_digit_multiplier_pkg.sv
// Shared constants, state encoding and operand-range helper for the
// single-digit BCD shift-and-add multiplier.
package mult_pkg;

  localparam int OPW  = 4;
  localparam int PW   = 7;
  localparam int ITER = OPW;

  localparam logic [OPW-1:0] MAX_DIGIT = 4'd9;
  localparam logic [1:0]     CNT_LAST  = 2'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  function automatic logic is_digit(input logic [OPW-1:0] v);
    return (v <= MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_digit_multiplier_if.sv
// Request/response bundle between an operand source and the digit multiplier.
interface bcd_digit_multiplier_if;
  import mult_pkg::*;

  logic           start;
  logic [OPW-1:0] a;
  logic [OPW-1:0] b;
  logic           busy;
  logic           done;
  logic           err;
  logic [PW-1:0]  product;

  modport master (
    output start, a, b,
    input  busy, done, err, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, err, product
  );

endinterface

// File: rtl/bcd_digit_multiplier.sv
// Four-cycle shift-and-add multiplier for two decimal digits; the product
// register only updates on completion so the display never sees partial sums.
module bcd_digit_multiplier
  import mult_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  bcd_digit_multiplier_if.slave bus
);

  mult_state_t    state_q, state_d;
  logic [PW-1:0]  acc_q, acc_d;
  logic [PW-1:0]  mcand_q, mcand_d;
  logic [OPW-1:0] mplier_q, mplier_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [PW-1:0]  product_q, product_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           accept;
  logic           operands_ok;
  logic [PW-1:0]  sum;

  // Requests arriving while RUN is in progress are dropped, not queued.
  assign accept      = bus.start && (state_q != RUN);
  assign operands_ok = is_digit(bus.a) && is_digit(bus.b);
  assign sum         = acc_q + (mplier_q[0] ? mcand_q : {PW{1'b0}});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      acc_q     <= {PW{1'b0}};
      mcand_q   <= {PW{1'b0}};
      mplier_q  <= {OPW{1'b0}};
      cnt_q     <= 2'd0;
      product_q <= {PW{1'b0}};
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (operands_ok) state_d = RUN;
          else             state_d = DONE;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        if (cnt_q == CNT_LAST) state_d = DONE;
        else                   state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they align with it.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      RUN:     busy_d = 1'b1;
      DONE:    done_d = 1'b1;
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    err_d     = err_q;
    if (accept) begin
      if (operands_ok) begin
        mcand_d  = {{(PW-OPW){1'b0}}, bus.a};
        mplier_d = bus.b;
        acc_d    = {PW{1'b0}};
        cnt_d    = 2'd0;
        err_d    = 1'b0;
      end else begin
        product_d = {PW{1'b0}};
        err_d     = 1'b1;
      end
    end else if (state_q == RUN) begin
      acc_d    = sum;
      mcand_d  = {mcand_q[PW-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[OPW-1:1]};
      cnt_d    = cnt_q + 2'd1;
      if (cnt_q == CNT_LAST) product_d = sum;
      else                   product_d = product_q;
    end else begin
      product_d = product_q;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_bcd_digit_multiplier.sv
// Directed and randomized checks of the digit multiplier against plain a*b.
module tb_bcd_digit_multiplier;
  import mult_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  int            checks = 0;
  int            errors = 0;
  logic [PW-1:0] last_prod = '0;

  bcd_digit_multiplier_if mif ();

  bcd_digit_multiplier dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (mif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // While done stays high with no request or reset at the edge, product must hold.
  logic          start_at_edge = 1'b0;
  logic          rst_at_edge = 1'b1;
  logic          prev_done = 1'b0;
  logic [PW-1:0] prev_prod = '0;

  always @(posedge clk) begin
    start_at_edge <= mif.start;
    rst_at_edge   <= rst;
  end

  always @(negedge clk) begin
    if (prev_done === 1'b1 && mif.done === 1'b1 && start_at_edge === 1'b0 && rst_at_edge === 1'b0)
      check("done_hold", 32'(mif.product), 32'(prev_prod));
    prev_done <= mif.done;
    prev_prod <= mif.product;
  end

  // One request through to completion; poke injects an ignored start during RUN.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit poke, input string tag);
    logic legal;
    int   exp;
    legal = (a <= 4'd9) && (b <= 4'd9);
    exp   = legal ? int'(a) * int'(b) : 0;
    mif.a = a;
    mif.b = b;
    mif.start = 1'b1;
    tick();
    mif.start = 1'b0;
    if (!legal) begin
      check({tag, ":err"}, 32'(mif.err), 32'd1);
      check({tag, ":done"}, 32'(mif.done), 32'd1);
      check({tag, ":busy"}, 32'(mif.busy), 32'd0);
      check({tag, ":prod"}, 32'(mif.product), 32'd0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        check({tag, ":run_busy"}, 32'(mif.busy), 32'd1);
        check({tag, ":run_done"}, 32'(mif.done), 32'd0);
        check({tag, ":run_prod"}, 32'(mif.product), 32'(last_prod));
        mif.a = 4'($urandom_range(0, 15));
        mif.b = 4'($urandom_range(0, 15));
        mif.start = (poke && i == 1) ? 1'b1 : 1'b0;
        if (poke && i == 1) begin
          mif.a = 4'd1;
          mif.b = 4'd1;
        end
        tick();
      end
      mif.start = 1'b0;
      check({tag, ":done"}, 32'(mif.done), 32'd1);
      check({tag, ":busy"}, 32'(mif.busy), 32'd0);
      check({tag, ":err"}, 32'(mif.err), 32'd0);
      check({tag, ":prod"}, 32'(mif.product), 32'(exp));
    end
    last_prod = 7'(exp);
  endtask

  initial begin
    mif.start = 1'b0;
    mif.a = 4'd0;
    mif.b = 4'd0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(mif.busy), 32'd0);
    check("rst_done", 32'(mif.done), 32'd0);
    check("rst_err", 32'(mif.err), 32'd0);
    check("rst_prod", 32'(mif.product), 32'd0);
    tick();
    check("idle_done", 32'(mif.done), 32'd0);

    run_op(4'd9, 4'd9, 1'b0, "9x9");
    run_op(4'd3, 4'd4, 1'b0, "3x4");
    run_op(4'd0, 4'd7, 1'b0, "0x7");
    run_op(4'd10, 4'd2, 1'b0, "10x2");
    run_op(4'd2, 4'd5, 1'b0, "2x5");
    run_op(4'd7, 4'd6, 1'b1, "7x6_poke");
    run_op(4'd3, 4'd15, 1'b0, "3x15");

    // Reset two edges into an 8x8 run discards it and returns to IDLE.
    mif.a = 4'd8;
    mif.b = 4'd8;
    mif.start = 1'b1;
    tick();
    mif.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", 32'(mif.busy), 32'd0);
    check("mid_rst_done", 32'(mif.done), 32'd0);
    check("mid_rst_err", 32'(mif.err), 32'd0);
    check("mid_rst_prod", 32'(mif.product), 32'd0);
    check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    last_prod = '0;
    tick();
    check("post_rst_prod", 32'(mif.product), 32'd0);
    check("post_rst_busy", 32'(mif.busy), 32'd0);

    // Start held high: done lasts one cycle, then the next run begins.
    mif.a = 4'd4;
    mif.b = 4'd5;
    mif.start = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("hold_run_prod", 32'(mif.product), 32'd0);
    tick();
    check("hold_done1", 32'(mif.done), 32'd1);
    check("hold_prod1", 32'(mif.product), 32'd20);
    tick();
    check("hold_redone", 32'(mif.done), 32'd0);
    check("hold_rebusy", 32'(mif.busy), 32'd1);
    check("hold_keep", 32'(mif.product), 32'd20);
    mif.a = 4'd6;
    mif.b = 4'd3;
    for (int k = 0; k < 3; k++) tick();
    check("hold_busy_e3", 32'(mif.busy), 32'd1);
    tick();
    check("hold_done2", 32'(mif.done), 32'd1);
    check("hold_prod2", 32'(mif.product), 32'd20);
    mif.start = 1'b0;
    last_prod = 7'd20;
    tick();
    tick();
    check("hold_idle_done", 32'(mif.done), 32'd1);

    for (int x = 0; x <= 9; x++)
      for (int y = 0; y <= 9; y++)
        run_op(4'(x), 4'(y), 1'b0, "sweep");

    for (int n = 0; n < 40; n++)
      run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, "rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
